// File: rtl/cmd_time_scheduler.sv
// rtl/cmd_time_scheduler.sv - scans command memory for the earliest due entry, dispatches it and requests its erase
module cmd_time_scheduler #(
    parameter int N_IDX = 255
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         EN,
    input  logic [63:0]  TIME_NOW,
    input  logic         WR_BUSY,
    output logic [7:0]   RD_ADDR,
    output logic         RD_EN,
    input  logic [337:0] MEM_Q,
    output logic         CLR_REQ,
    output logic [7:0]   CLR_ADDR,
    input  logic         CLR_ACK,
    output logic [47:0]  FREQ_z,
    output logic [47:0]  FREQ_STEP_z,
    output logic [31:0]  FREQ_RATE_z,
    output logic [63:0]  TIME_START_z,
    output logic [15:0]  N_impuls_z,
    output logic [1:0]   TYPE_impulse_z,
    output logic [31:0]  Interval_Ti_z,
    output logic [31:0]  Interval_Tp_z,
    output logic [31:0]  Tblank1_z,
    output logic [31:0]  Tblank2_z,
    output logic         CMD_STROBE,
    output logic         CMD_LATE,
    output logic [15:0]  CMD_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_EVAL,
        S_FETCH,
        S_LOAD,
        S_CLR,
        S_CLR_WAIT
    } state_t;

    localparam logic [7:0] LAST_ADDR = 8'(N_IDX);

    state_t state;
    state_t state_nxt;

    logic [7:0]  rd_addr;
    logic        issue_done;
    logic        pend_valid;
    logic [7:0]  pend_addr;
    logic        min_valid;
    logic [63:0] min_time;
    logic [7:0]  min_addr;

    logic [63:0] q_time_start;
    logic        q_empty;
    logic        q_better;
    logic        due;
    logic        clr_active;

    assign q_time_start = MEM_Q[337:274];
    assign q_empty      = (q_time_start == 64'hFFFF_FFFF_FFFF_FFFF);
    // Strict less-than keeps the lower address on ties because addresses arrive in ascending order.
    assign q_better     = pend_valid && !q_empty && (!min_valid || (q_time_start < min_time));
    assign due          = min_valid && (min_time <= TIME_NOW);
    assign clr_active   = (state == S_CLR) || (state == S_CLR_WAIT);

    assign RD_ADDR  = rd_addr;
    assign RD_EN    = ((state == S_SCAN) && !issue_done) || (state == S_FETCH);
    assign CLR_REQ  = clr_active;
    assign CLR_ADDR = clr_active ? min_addr : 8'd0;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The erase handshake is never abandoned by EN; only reset can cut it short.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (EN && !WR_BUSY) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!EN || WR_BUSY) begin
                    state_nxt = S_IDLE;
                end else if (issue_done) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!EN || !due) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = EN ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                state_nxt = EN ? S_CLR : S_IDLE;
            end
            S_CLR: begin
                state_nxt = CLR_ACK ? S_IDLE : S_CLR_WAIT;
            end
            S_CLR_WAIT: begin
                if (CLR_ACK) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Scan pipeline: address k is issued in one cycle and its data judged in the next,
    // so a pass is N_IDX+1 issue cycles plus one tail cycle for the last word.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr    <= 8'd0;
            issue_done <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 8'd0;
            min_valid  <= 1'b0;
            min_time   <= 64'd0;
            min_addr   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_SCAN) begin
                        rd_addr    <= 8'd0;
                        issue_done <= 1'b0;
                        pend_valid <= 1'b0;
                        min_valid  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (q_better) begin
                        min_valid <= 1'b1;
                        min_time  <= q_time_start;
                        min_addr  <= pend_addr;
                    end
                    if (!issue_done) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= rd_addr;
                        if (rd_addr == LAST_ADDR) begin
                            issue_done <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + 8'd1;
                        end
                    end else begin
                        pend_valid <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (state_nxt == S_FETCH) begin
                        rd_addr <= min_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            TIME_START_z   <= 64'd0;
            FREQ_z         <= 48'd0;
            FREQ_STEP_z    <= 48'd0;
            FREQ_RATE_z    <= 32'd0;
            N_impuls_z     <= 16'd0;
            TYPE_impulse_z <= 2'd0;
            Interval_Ti_z  <= 32'd0;
            Interval_Tp_z  <= 32'd0;
            Tblank1_z      <= 32'd0;
            Tblank2_z      <= 32'd0;
            CMD_STROBE     <= 1'b0;
            CMD_LATE       <= 1'b0;
            CMD_CNT        <= 16'd0;
        end else begin
            CMD_STROBE <= 1'b0;
            if ((state == S_LOAD) && (state_nxt == S_CLR)) begin
                TIME_START_z   <= MEM_Q[337:274];
                FREQ_z         <= MEM_Q[273:226];
                FREQ_STEP_z    <= MEM_Q[225:178];
                FREQ_RATE_z    <= MEM_Q[177:146];
                N_impuls_z     <= MEM_Q[145:130];
                TYPE_impulse_z <= MEM_Q[129:128];
                Interval_Ti_z  <= MEM_Q[127:96];
                Interval_Tp_z  <= MEM_Q[95:64];
                Tblank1_z      <= MEM_Q[63:32];
                Tblank2_z      <= MEM_Q[31:0];
                CMD_STROBE     <= 1'b1;
                CMD_LATE       <= (q_time_start < TIME_NOW);
                CMD_CNT        <= CMD_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_time_scheduler.sv
// tb/tb_cmd_time_scheduler.sv - self-checking bench for cmd_time_scheduler with memory and erase-writer models
module tb_cmd_time_scheduler;

    logic         CLK;
    logic         rst_n;
    logic         EN;
    logic [63:0]  TIME_NOW;
    logic         WR_BUSY;
    logic [7:0]   RD_ADDR;
    logic         RD_EN;
    logic [337:0] MEM_Q;
    logic         CLR_REQ;
    logic [7:0]   CLR_ADDR;
    logic         CLR_ACK;
    logic [47:0]  FREQ_z;
    logic [47:0]  FREQ_STEP_z;
    logic [31:0]  FREQ_RATE_z;
    logic [63:0]  TIME_START_z;
    logic [15:0]  N_impuls_z;
    logic [1:0]   TYPE_impulse_z;
    logic [31:0]  Interval_Ti_z;
    logic [31:0]  Interval_Tp_z;
    logic [31:0]  Tblank1_z;
    logic [31:0]  Tblank2_z;
    logic         CMD_STROBE;
    logic         CMD_LATE;
    logic [15:0]  CMD_CNT;

    cmd_time_scheduler #(.N_IDX(255)) dut (
        .CLK(CLK), .rst_n(rst_n), .EN(EN), .TIME_NOW(TIME_NOW), .WR_BUSY(WR_BUSY),
        .RD_ADDR(RD_ADDR), .RD_EN(RD_EN), .MEM_Q(MEM_Q),
        .CLR_REQ(CLR_REQ), .CLR_ADDR(CLR_ADDR), .CLR_ACK(CLR_ACK),
        .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
        .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z), .TYPE_impulse_z(TYPE_impulse_z),
        .Interval_Ti_z(Interval_Ti_z), .Interval_Tp_z(Interval_Tp_z),
        .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
        .CMD_STROBE(CMD_STROBE), .CMD_LATE(CMD_LATE), .CMD_CNT(CMD_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [337:0] make_word(input logic [7:0] a, input logic [63:0] ts);
        return {ts, {40'h10_0000_0000, a}, {40'h20_0000_0000, a}, {24'h30_0000, a}, {8'h40, a},
                a[1:0], {24'h50_0000, a}, {24'h60_0000, a}, {24'h70_0000, a}, {24'h80_0000, a}};
    endfunction

    // Command memory: one-cycle registered read, bulk clear, one write port, erase on accepted clear.
    logic [337:0] mem [0:255];
    logic         mem_clr;
    logic         mem_we;
    logic [7:0]   mem_wa;
    logic [337:0] mem_wd;

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= make_word(8'(i), 64'hFFFF_FFFF_FFFF_FFFF);
        end else if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        if (CLR_REQ && CLR_ACK) mem[CLR_ADDR][337:274] <= 64'hFFFF_FFFF_FFFF_FFFF;
        if (RD_EN) MEM_Q <= mem[RD_ADDR];
    end

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] ts;
        logic        late;
    } exp_t;

    typedef struct {
        logic [7:0]  a_addr;
        logic [63:0] a_ts;
        logic        b_use;
        logic [7:0]  b_addr;
        logic [63:0] b_ts;
        logic [63:0] now;
        logic        exp_disp;
        logic [7:0]  exp_addr;
        logic [63:0] exp_ts;
        logic        exp_late;
    } vec_t;

    exp_t   sbq[$];
    vec_t   vecs[8];
    int     checks, errors;
    int     strobe_cnt, clr_rise_cnt, clr_fall_cnt, clr_len, last_clr_len;
    int     ack_delay, req_cycles;
    logic   clr_prev, tick_en;
    logic [15:0] exp_cnt;
    logic [7:0]  last_addr;

    task automatic chk(input string name, input logic [373:0] act, input logic [373:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (CMD_STROBE) begin
            if (sbq.size() == 0) begin
                chk("strobe_unexpected", 374'(CMD_STROBE), 374'(0));
            end else begin
                e = sbq.pop_front();
                exp_cnt = exp_cnt + 16'd1;
                chk("z_fields", 374'({TIME_START_z, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z,
                     TYPE_impulse_z, Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z}),
                    374'(make_word(e.addr, e.ts)));
                chk("cmd_late", 374'(CMD_LATE), 374'(e.late));
                chk("cmd_cnt", 374'(CMD_CNT), 374'(exp_cnt));
                last_addr = e.addr;
            end
            strobe_cnt++;
        end
        if (CLR_REQ && !clr_prev) begin
            chk("clr_addr", 374'(CLR_ADDR), 374'(last_addr));
            clr_rise_cnt++;
        end
        if (CLR_REQ) clr_len++;
        if (!CLR_REQ && clr_prev) begin
            clr_fall_cnt++;
            last_clr_len = clr_len;
            clr_len = 0;
        end
        clr_prev = CLR_REQ;
    endtask

    // Writer model: accepts the erase after ack_delay full cycles of request.
    task automatic responder();
        if (CLR_REQ) begin
            req_cycles++;
            if (req_cycles > ack_delay) CLR_ACK = 1'b1;
        end else begin
            CLR_ACK = 1'b0;
            req_cycles = 0;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        monitor();
        responder();
        if (tick_en) TIME_NOW = TIME_NOW + 64'd1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [63:0] ts);
        mem_we = 1'b1; mem_wa = a; mem_wd = make_word(a, ts);
        tick();
        mem_we = 1'b0;
    endtask

    task automatic mem_clear();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; EN = 1'b0; WR_BUSY = 1'b0;
        sbq.delete();
        exp_cnt = 16'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 374'(strobe_cnt >= target), 374'(1));
    endtask

    task automatic wait_clr_fall(input int target, input int budget);
        int n = 0;
        while (clr_fall_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("clr_done_timeout", 374'(clr_fall_cnt >= target), 374'(1));
    endtask

    initial begin
        int base, fbase, rbase, passes, n;
        checks = 0; errors = 0;
        strobe_cnt = 0; clr_rise_cnt = 0; clr_fall_cnt = 0; clr_len = 0; last_clr_len = 0;
        ack_delay = 0; req_cycles = 0; clr_prev = 1'b0; tick_en = 1'b0;
        exp_cnt = 16'd0; last_addr = 8'd0;
        rst_n = 1'b0; EN = 1'b0; WR_BUSY = 1'b0; TIME_NOW = 64'd0; CLR_ACK = 1'b0;
        mem_clr = 1'b0; mem_we = 1'b0; mem_wa = 8'd0; mem_wd = '0;

        vecs[0] = '{8'd5,   64'd1000, 1'b0, 8'd0,  64'd0,   64'd1000, 1'b1, 8'd5,   64'd1000, 1'b0};
        vecs[1] = '{8'd5,   64'd1000, 1'b0, 8'd0,  64'd0,   64'd1001, 1'b1, 8'd5,   64'd1000, 1'b1};
        vecs[2] = '{8'd3,   64'd500,  1'b1, 8'd7,  64'd500, 64'd600,  1'b1, 8'd3,   64'd500,  1'b1};
        vecs[3] = '{8'd200, 64'd50,   1'b1, 8'd10, 64'd60,  64'd100,  1'b1, 8'd200, 64'd50,   1'b1};
        vecs[4] = '{8'd255, 64'd0,    1'b0, 8'd0,  64'd0,   64'd0,    1'b1, 8'd255, 64'd0,    1'b0};
        vecs[5] = '{8'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 8'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 8'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[6] = '{8'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'd9, 64'd100, 64'd200, 1'b1, 8'd9, 64'd100, 1'b1};
        vecs[7] = '{8'd9,   64'd2000, 1'b0, 8'd0,  64'd0,   64'd1999, 1'b0, 8'd0,   64'd0,    1'b0};

        repeat (2) tick();
        chk("reset_outputs", {RD_ADDR, RD_EN, CLR_REQ, CLR_ADDR, CMD_STROBE, CMD_LATE, CMD_CNT,
            TIME_START_z, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z, TYPE_impulse_z,
            Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z}, 374'(0));
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            reset_dut();
            mem_clear();
            mem_write(vecs[v].a_addr, vecs[v].a_ts);
            if (vecs[v].b_use) mem_write(vecs[v].b_addr, vecs[v].b_ts);
            TIME_NOW = vecs[v].now;
            ack_delay = 0;
            base = strobe_cnt; fbase = clr_fall_cnt; rbase = clr_rise_cnt;
            if (vecs[v].exp_disp) begin
                sbq.push_back('{vecs[v].exp_addr, vecs[v].exp_ts, vecs[v].exp_late});
                EN = 1'b1;
                wait_strobes(base + 1, 600, "vec_dispatch_timeout");
                wait_clr_fall(fbase + 1, 50);
            end else begin
                EN = 1'b1;
                repeat (700) tick();
                chk("vec_no_dispatch", 374'(strobe_cnt - base), 374'(0));
                chk("vec_no_clr", 374'(clr_rise_cnt - rbase), 374'(0));
            end
            EN = 1'b0;
        end

        // All slots empty: EN low holds idle, EN high keeps scanning without dispatch.
        reset_dut();
        mem_clear();
        TIME_NOW = 64'd12345;
        base = strobe_cnt; rbase = clr_rise_cnt; n = 0;
        repeat (20) begin
            tick();
            if (RD_EN) n++;
        end
        chk("en_low_no_read", 374'(n), 374'(0));
        EN = 1'b1; passes = 0;
        repeat (1000) begin
            tick();
            if (RD_EN && RD_ADDR == 8'd0) passes++;
        end
        chk("empty_repeated_passes", 374'(passes >= 3), 374'(1));
        chk("empty_no_strobe", 374'(strobe_cnt - base), 374'(0));
        chk("empty_no_clr", 374'(clr_rise_cnt - rbase), 374'(0));

        // Time advancing across the start time: exactly one dispatch of slot 5.
        reset_dut();
        mem_clear();
        mem_write(8'd5, 64'd1000);
        TIME_NOW = 64'd900;
        base = strobe_cnt;
        sbq.push_back('{8'd5, 64'd1000, 1'b1});
        tick_en = 1'b1;
        EN = 1'b1;
        while (TIME_NOW < 64'd1300) tick();
        tick_en = 1'b0;
        chk("ticking_single_dispatch", 374'(strobe_cnt - base), 374'(1));
        chk("ticking_queue_drained", 374'(sbq.size()), 374'(0));

        // Equal start times: lower slot first, the other on the next pass; CMD_CNT reaches 2.
        reset_dut();
        mem_clear();
        mem_write(8'd3, 64'd500);
        mem_write(8'd7, 64'd500);
        TIME_NOW = 64'd600;
        base = strobe_cnt;
        sbq.push_back('{8'd3, 64'd500, 1'b1});
        sbq.push_back('{8'd7, 64'd500, 1'b1});
        EN = 1'b1;
        wait_strobes(base + 2, 1200, "tie_dispatch_timeout");

        // WR_BUSY mid-scan aborts the pass; the next pass dispatches.
        reset_dut();
        mem_clear();
        mem_write(8'd5, 64'd10);
        TIME_NOW = 64'd100;
        base = strobe_cnt;
        EN = 1'b1;
        n = 0;
        while (!(RD_EN && RD_ADDR == 8'd100) && n < 400) begin
            tick();
            n++;
        end
        chk("busy_reach_addr100", 374'(RD_EN && RD_ADDR == 8'd100), 374'(1));
        WR_BUSY = 1'b1;
        tick();
        WR_BUSY = 1'b0;
        repeat (200) tick();
        chk("busy_pass_aborted", 374'(strobe_cnt - base), 374'(0));
        sbq.push_back('{8'd5, 64'd10, 1'b1});
        wait_strobes(base + 1, 400, "busy_redispatch_timeout");

        // Delayed acknowledge: request held for exactly 11 observed cycles, then idle.
        reset_dut();
        mem_clear();
        mem_write(8'd30, 64'd5);
        TIME_NOW = 64'd10;
        ack_delay = 10;
        base = strobe_cnt; fbase = clr_fall_cnt;
        sbq.push_back('{8'd30, 64'd5, 1'b1});
        EN = 1'b1;
        wait_strobes(base + 1, 600, "ackdly_dispatch_timeout");
        wait_clr_fall(fbase + 1, 100);
        chk("ackdly_req_length", 374'(last_clr_len), 374'(11));
        chk("ackdly_idle_no_read", 374'(RD_EN), 374'(0));
        ack_delay = 0;

        // Reset while waiting for acknowledge: outputs clear at once, entry survives and is re-dispatched once.
        reset_dut();
        mem_clear();
        mem_write(8'd20, 64'd100);
        TIME_NOW = 64'd200;
        ack_delay = 1000000;
        base = strobe_cnt;
        sbq.push_back('{8'd20, 64'd100, 1'b1});
        EN = 1'b1;
        wait_strobes(base + 1, 600, "rstclr_dispatch_timeout");
        repeat (3) tick();
        chk("rstclr_in_wait", 374'(CLR_REQ), 374'(1));
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1;
        chk("rstclr_outputs_zero", {RD_ADDR, RD_EN, CLR_REQ, CLR_ADDR, CMD_STROBE, CMD_LATE, CMD_CNT,
            TIME_START_z, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z, TYPE_impulse_z,
            Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z}, 374'(0));
        sbq.delete();
        exp_cnt = 16'd0;
        ack_delay = 0;
        repeat (2) tick();
        base = strobe_cnt; fbase = clr_fall_cnt;
        sbq.push_back('{8'd20, 64'd100, 1'b1});
        rst_n = 1'b1;
        wait_strobes(base + 1, 600, "rstclr_redispatch_timeout");
        wait_clr_fall(fbase + 1, 50);
        repeat (600) tick();
        chk("rstclr_dispatched_once", 374'(strobe_cnt - base), 374'(1));
        EN = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_time_scheduler.md
CMD_TIME_SCHEDULER -- requirements
Module: cmd_time_scheduler

Interface
REQ-001 Parameter N_IDX, default 255: highest command-memory address scanned.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 EN  in  1  scheduler enable; 0 = hold in IDLE.
REQ-005 TIME_NOW  in  64  current system time, monotonic, +1 per tick.
REQ-006 WR_BUSY  in  1  writer busy (clear/write in progress).
REQ-007 RD_ADDR  out  8  command-memory read address.
REQ-008 RD_EN  out  1  command-memory read enable.
REQ-009 MEM_Q  in  338  read data; bits [337:274] TIME_START, [273:226] FREQ, [225:178] FREQ_STEP, [177:146] FREQ_RATE, [145:130] N_impuls, [129:128] TYPE_impulse, [127:96] Interval_Ti, [95:64] Interval_Tp, [63:32] Tblank1, [31:0] Tblank2.
REQ-010 CLR_REQ  out  1  request to writer to erase slot CLR_ADDR.
REQ-011 CLR_ADDR  out  8  slot to erase.
REQ-012 CLR_ACK  in  1  writer accepted erase.
REQ-013 FREQ_z 48, FREQ_STEP_z 48, FREQ_RATE_z 32, TIME_START_z 64, N_impuls_z 16, TYPE_impulse_z 2, Interval_Ti_z 32, Interval_Tp_z 32, Tblank1_z 32, Tblank2_z 32  out  dispatched command fields.
REQ-014 CMD_STROBE  out  1  one-cycle pulse: *_z fields valid and new.
REQ-015 CMD_LATE  out  1  dispatched TIME_START < TIME_NOW at dispatch.
REQ-016 CMD_CNT  out  16  count of dispatched commands.

Function
REQ-017 Memory read latency SHALL be one cycle: MEM_Q on edge k+1 reflects RD_ADDR with RD_EN=1 at edge k.
REQ-018 Slot empty iff MEM_Q[337:274] = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-019 States: IDLE, SCAN, EVAL, FETCH, LOAD, CLR, CLR_WAIT.
REQ-020 IDLE -> SCAN when EN=1 and WR_BUSY=0; RD_ADDR<=0, min-tracker invalidated.
REQ-021 SCAN: RD_EN=1, RD_ADDR increments 0..N_IDX, one address per cycle; each returned word compared to tracker.
REQ-022 Tracker update: non-empty word with TIME_START strictly less than tracked minimum (or tracker invalid) replaces min time/address; ties keep lower address.
REQ-023 SCAN -> EVAL after data for address N_IDX is evaluated; pass length N_IDX+2 cycles.
REQ-024 WR_BUSY=1 during SCAN aborts pass -> IDLE, no dispatch.
REQ-025 EVAL: no valid entry, or min time > TIME_NOW -> IDLE; else -> FETCH.
REQ-026 FETCH: re-read min address (RD_EN=1 one cycle) -> LOAD.
REQ-027 LOAD: register all MEM_Q fields into *_z, pulse CMD_STROBE one cycle, CMD_LATE <= (TIME_START < TIME_NOW), CMD_CNT +1 wrapping 16'hFFFF->0 -> CLR.
REQ-028 CLR: CLR_REQ=1, CLR_ADDR=min address, held until CLR_ACK sampled 1 (CLR_WAIT); CLR_REQ drops next cycle -> IDLE.
REQ-029 *_z and CMD_LATE hold until next LOAD.
REQ-030 EN=0 in any state other than CLR/CLR_WAIT -> IDLE next cycle; pending CLR handshake completes first.
REQ-031 RD_EN=0 outside SCAN/FETCH.
REQ-032 All comparisons unsigned 64-bit.

Reset
REQ-033 rst_n low: state IDLE, all outputs 0, CMD_CNT 0, tracker invalid, immediately and asynchronously.
REQ-034 Reset mid-SCAN or mid-CLR SHALL abandon operation; no CMD_STROBE or CLR_REQ after release until a new pass.

Verification
REQ-035 All slots empty, EN=1 -> repeated passes, CMD_STROBE never, CLR_REQ never.
REQ-036 Slot 5 TIME_START=1000, TIME_NOW=900..1300 -> single CMD_STROBE with TIME_START_z=1000, CLR_ADDR=5, CMD_CNT=1, CMD_LATE per REQ-027 after first pass ending with TIME_NOW>=1000.
REQ-037 Slots 3 and 7 both TIME_START=500, TIME_NOW=600 -> slot 3 dispatched first (CMD_LATE=1), slot 7 next pass.
REQ-038 WR_BUSY pulsed at scan address 100 -> no dispatch that pass; dispatch on following pass.
REQ-039 CLR_ACK delayed 10 cycles -> CLR_REQ high exactly until ACK sampled, then 0, state IDLE.
REQ-040 rst_n low during CLR_WAIT -> all outputs 0 immediately; after release, entry re-dispatched once (not erased).
